// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: Tuse/Tnew RAW detection,
// multiply/divide occupancy countdown and a stalled-cycle performance counter.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        pc_en,
    output logic        d_pause,
    output logic        e_flush,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] md_cnt;
    logic       rs_hz;
    logic       rt_hz;
    logic       md_hz;

    // A producer blocks D only when its result arrives later than D needs it.
    always_comb begin
        rs_hz = (D_rs != 5'd0) &&
                (((D_rs == E_wa) && (E_tnew > D_rs_tuse)) ||
                 ((D_rs == M_wa) && (M_tnew > D_rs_tuse)));
        rt_hz = (D_rt != 5'd0) &&
                (((D_rt == E_wa) && (E_tnew > D_rt_tuse)) ||
                 ((D_rt == M_wa) && (M_tnew > D_rt_tuse)));
        md_hz = D_is_md && (md_busy || E_md_start);
    end

    assign md_busy = (md_cnt != 4'd0);
    assign stall   = rs_hz || rt_hz || md_hz;
    assign pc_en   = ~stall;
    assign d_pause = stall;
    assign e_flush = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (E_md_start) begin
            md_cnt <= E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  D_rs = '0, D_rt = '0, E_wa = '0, M_wa = '0;
    logic [1:0]  D_rs_tuse = 2'd3, D_rt_tuse = 2'd3, E_tnew = '0, M_tnew = '0;
    logic        D_is_md = 1'b0, E_md_start = 1'b0, E_md_div = 1'b0;
    logic        stall, pc_en, d_pause, e_flush, md_busy;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    // Model state: remaining busy cycles of the MDU and stalled-cycle tally.
    int          m_busy_left = 0;
    logic [31:0] m_count = 32'd0;

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_is_md(D_is_md), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .stall(stall), .pc_en(pc_en), .d_pause(d_pause), .e_flush(e_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit reg_waits(logic [4:0] r, logic [1:0] tuse);
        if (r == 5'd0) return 1'b0;
        if (r == E_wa && int'(E_tnew) > int'(tuse)) return 1'b1;
        if (r == M_wa && int'(M_tnew) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        bit md_wait;
        md_wait = D_is_md && (m_busy_left > 0 || E_md_start);
        return reg_waits(D_rs, D_rs_tuse) || reg_waits(D_rt, D_rt_tuse) || md_wait;
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] rs_tuse, input logic [1:0] rt_tuse,
                                 input logic is_md, input logic [4:0] ewa, input logic [1:0] etnew,
                                 input logic [4:0] mwa, input logic [1:0] mtnew,
                                 input logic start, input logic div);
        @(posedge clk);
        #1;
        reset = rst; D_rs = rs; D_rt = rt; D_rs_tuse = rs_tuse; D_rt_tuse = rt_tuse;
        D_is_md = is_md; E_wa = ewa; E_tnew = etnew; M_wa = mwa; M_tnew = mtnew;
        E_md_start = start; E_md_div = div;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_busy_left = 0;
            m_count = 32'd0;
        end else begin
            if (model_stall()) m_count = m_count + 32'd1;
            if (E_md_start) m_busy_left = E_md_div ? 10 : 5;
            else if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit s;
            s = model_stall();
            checkOutput("model_stall", {31'd0, stall}, {31'd0, s});
            checkOutput("model_pc_en", {31'd0, pc_en}, {31'd0, ~s});
            checkOutput("model_d_pause", {31'd0, d_pause}, {31'd0, s});
            checkOutput("model_e_flush", {31'd0, e_flush}, {31'd0, s});
            checkOutput("model_md_busy", {31'd0, md_busy}, {31'd0, m_busy_left > 0});
            checkOutput("model_stall_cnt", stall_cnt, m_count);
        end
    end

    initial begin
        int busy_cycles;

        // Reset state.
        applyStimulus(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
        checkOutput("reset_md_busy", {31'd0, md_busy}, 32'd0);
        checkOutput("reset_pc_en", {31'd0, pc_en}, 32'd1);
        checkOutput("reset_e_flush", {31'd0, e_flush}, 32'd0);

        // rs against E producer.
        applyStimulus(0, 8, 0, 0, 3, 0, 8, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rs_e_stall", {31'd0, stall}, 32'd1);
        checkOutput("rs_e_pc_en", {31'd0, pc_en}, 32'd0);
        checkOutput("rs_e_d_pause", {31'd0, d_pause}, 32'd1);
        checkOutput("rs_e_e_flush", {31'd0, e_flush}, 32'd1);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rs_zero_reg", {31'd0, stall}, 32'd0);
        applyStimulus(0, 8, 0, 0, 3, 0, 8, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rs_tnew_ready", {31'd0, stall}, 32'd0);

        // rt against M producer.
        applyStimulus(0, 0, 9, 3, 1, 0, 0, 0, 9, 2, 0, 0);
        @(negedge clk);
        checkOutput("rt_m_stall", {31'd0, stall}, 32'd1);
        applyStimulus(0, 0, 9, 3, 1, 0, 0, 0, 9, 1, 0, 0);
        @(negedge clk);
        checkOutput("rt_m_ready", {31'd0, stall}, 32'd0);
        checkOutput("cnt_after_raw", stall_cnt, 32'd2);

        // Divide occupancy: 10 busy cycles, each stalling the waiting md instr.
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!md_busy) break;
            busy_cycles++;
            checkOutput("div_busy_stall", {31'd0, stall}, 32'd1);
            applyStimulus(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("div_busy_len", busy_cycles, 32'd10);
        checkOutput("div_after_stall", {31'd0, stall}, 32'd0);
        checkOutput("div_cnt", stall_cnt, 32'd12);

        // Multiply occupancy: 5 busy cycles.
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!md_busy) break;
            busy_cycles++;
            applyStimulus(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("mult_busy_len", busy_cycles, 32'd5);
        checkOutput("mult_cnt", stall_cnt, 32'd17);

        // Reset in the middle of a countdown.
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_mid_busy_before", {31'd0, md_busy}, 32'd1);
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_mid_busy_after", {31'd0, md_busy}, 32'd0);
        checkOutput("rst_mid_cnt", stall_cnt, 32'd0);

        // Simultaneous RAW and MD hazard counts once.
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 4, 0, 0, 3, 1, 4, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("dual_hazard_cnt", stall_cnt, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 149) == 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        // Counter wrap: preload near the top and keep stalling.
        applyStimulus(0, 6, 0, 0, 3, 0, 6, 3, 0, 0, 0, 0);
        @(negedge clk);
        m_count = 32'hFFFF_FFFE;
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        applyStimulus(0, 6, 0, 0, 3, 0, 6, 3, 0, 0, 0, 0);
        applyStimulus(0, 6, 0, 0, 3, 0, 6, 3, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wrap_zero", stall_cnt, 32'd0);
        applyStimulus(0, 6, 0, 0, 3, 0, 6, 3, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wrap_one", stall_cnt, 32'd1);

        applyStimulus(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
